// File: rtl/sum_display_driver.sv
// rtl/sum_display_driver.sv - 5-bit sum to two-digit multiplexed 7-segment driver
module sum_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       cout,
    input  logic [3:0] S,
    output logic       busy,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      value;
    logic [3:0]      tens;
    logic [3:0]      units;
    logic [2:0]      shift_cnt;
    logic [3:0]      disp_tens;
    logic [3:0]      disp_units;
    logic [CW-1:0]   refresh_cnt;
    logic            sel;

    logic [3:0]      tens_adj;
    logic [3:0]      units_adj;
    logic [12:0]     dd_next;

    function automatic logic [6:0] encode(input logic [3:0] digit);
        case (digit)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b1111111;
        endcase
    endfunction

    // One double-dabble step: add-3 correction on each BCD digit, then shift the whole register left
    always_comb begin
        tens_adj  = (tens  >= 4'd5) ? tens  + 4'd3 : tens;
        units_adj = (units >= 4'd5) ? units + 4'd3 : units;
        dd_next   = {tens_adj, units_adj, value} << 1;
    end

    // Conversion FSM; display digits only ever change in LATCH so a running conversion never shows partial results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            value      <= 5'd0;
            tens       <= 4'd0;
            units      <= 4'd0;
            shift_cnt  <= 3'd0;
            disp_tens  <= 4'd0;
            disp_units <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        value     <= {cout, S};
                        tens      <= 4'd0;
                        units     <= 4'd0;
                        shift_cnt <= 3'd0;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    tens      <= dd_next[12:9];
                    units     <= dd_next[8:5];
                    value     <= dd_next[4:0];
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd4) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    disp_tens  <= tens;
                    disp_units <= units;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running refresh divider; flips the digit slot each time it wraps, independent of the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            sel         <= ~sel;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Digit multiplexing from registered state only; tens slot is blanked when the tens digit is zero
    always_comb begin
        an  = 2'b10;
        seg = encode(disp_units);
        if (sel) begin
            if (disp_tens != 4'd0) begin
                an  = 2'b01;
                seg = encode(disp_tens);
            end else begin
                an  = 2'b11;
                seg = 7'b1111111;
            end
        end
    end

endmodule

// File: tb/tb_sum_display_driver.sv
// tb/tb_sum_display_driver.sv - self-checking bench for sum_display_driver
module tb_sum_display_driver;

    logic       clk;
    logic       rst;
    logic       load;
    logic       cout;
    logic [3:0] S;
    logic       busy;
    logic [1:0] an;
    logic [6:0] seg;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [4:0] v;
        logic [3:0] t;
        logic [3:0] u;
    } vec_t;

    typedef struct {
        logic [3:0] t;
        logic [3:0] u;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] shown_units;

    sum_display_driver #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .cout (cout),
        .S    (S),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse load for one edge; expected digits go on the scoreboard when requested
    task automatic do_load(input logic [4:0] v, input bit push);
        exp_t e;
        @(negedge clk);
        load = 1'b1;
        {cout, S} = v;
        @(negedge clk);
        load = 1'b0;
        if (push) begin
            e.t = 4'(v / 10);
            e.u = 4'(v % 10);
            sb.push_back(e);
        end
    endtask

    // Count busy cycles (including the first one already observed); shown units must not change meanwhile
    task automatic wait_busy(input int already, input int exp_cycles);
        int n;
        n = already;
        while (busy && n < 20) begin
            if (an == 2'b10) check("hold_units", seg, enc(shown_units));
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, exp_cycles);
    endtask

    task automatic check_display(input logic [3:0] t, input logic [3:0] u);
        int n;
        n = 0;
        while (an != 2'b10 && n < 12) begin n++; @(negedge clk); end
        check("units_slot_seen", int'(n < 12), 1);
        check("units_seg", seg, enc(u));
        n = 0;
        while (an == 2'b10 && n < 12) begin n++; @(negedge clk); end
        check("tens_slot_seen", int'(n < 12), 1);
        if (t != 4'd0) begin
            check("tens_an", an, 2'b01);
            check("tens_seg", seg, enc(t));
        end else begin
            check("blank_an", an, 2'b11);
            check("blank_seg", seg, 7'b1111111);
        end
        shown_units = u;
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_display(e.t, e.u);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int last_t;
        int gap;
        logic [1:0] prev_an;
        n_checks    = 0;
        n_fail      = 0;
        shown_units = 4'd0;
        load = 1'b0;
        cout = 1'b0;
        S    = 4'd0;
        rst  = 1'b1;
        #1;
        check("rst_an", an, 2'b10);
        check("rst_seg", seg, 7'b1000000);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{5'd30, 4'd3, 4'd0};
        vecs[1] = '{5'd7,  4'd0, 4'd7};
        vecs[2] = '{5'd0,  4'd0, 4'd0};
        vecs[3] = '{5'd10, 4'd1, 4'd0};
        vecs[4] = '{5'd19, 4'd1, 4'd9};
        vecs[5] = '{5'd31, 4'd3, 4'd1};
        foreach (vecs[i]) begin
            exp_t e;
            do_load(vecs[i].v, 1'b0);
            e.t = vecs[i].t;
            e.u = vecs[i].u;
            sb.push_back(e);
            check("busy_after_load", busy, 1);
            wait_busy(0, 6);
            pop_and_check();
        end

        // sel cadence: with tens nonzero the enables alternate 10/01 every 4 cycles
        do_load(5'd30, 1'b1);
        wait_busy(0, 6);
        pop_and_check();
        prev_an = an;
        last_t  = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (an != prev_an) begin
                if (last_t >= 0) begin
                    gap = c - last_t;
                    check("sel_period", gap, 4);
                end
                last_t  = c;
                prev_an = an;
            end
        end

        // Load arriving mid-conversion is dropped, not queued
        do_load(5'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        load = 1'b1;
        {cout, S} = 5'd30;
        @(negedge clk);
        load = 1'b0;
        wait_busy(3, 6);
        pop_and_check();
        repeat (3) @(negedge clk);
        check("no_queued_load", busy, 0);

        // Reset mid-conversion aborts and clears the display
        do_load(5'd31, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_an", an, 2'b10);
        check("abort_seg", seg, 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        check_display(4'd0, 4'd0);
        load = 1'b1;
        {cout, S} = 5'd9;
        @(negedge clk);
        load = 1'b0;
        sb.push_back('{4'd0, 4'd9});
        check("first_edge_load", busy, 1);
        wait_busy(0, 6);
        pop_and_check();

        // Exhaustive sweep of every sum
        for (int v = 0; v < 32; v++) begin
            do_load(5'(v), 1'b1);
            wait_busy(0, 6);
            pop_and_check();
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sum_display_driver.md
SUM_DISPLAY_DRIVER -- requirements
Module: sum_display_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles per digit slot (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: request to capture a new sum.
REQ-005 The block SHALL have port cout, input, 1 bit: adder carry-out, forming bit 4 of the sum.
REQ-006 The block SHALL have port S, input, 4 bits: adder sum, forming bits 3:0 of the sum.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port an, output, 2 bits: digit enables, active-low; an[0] is units, an[1] is tens.
REQ-009 The block SHALL have port seg, output, 7 bits: segments, active-low, ordered {g,f,e,d,c,b,a}.

Function
REQ-010 The FSM SHALL have states IDLE, CONV and LATCH; busy SHALL be 1 in CONV and LATCH and 0 in IDLE.
REQ-011 In IDLE, a clock edge with load=1 SHALL capture value={cout,S} (0..31), clear tens/units scratch to 0, set shift count to 0 and enter CONV.
REQ-012 load SHALL be ignored while busy=1, including the cycle in which busy is about to fall; no queuing.
REQ-013 CONV SHALL perform one double-dabble step per clock: add 3 to any 4-bit scratch digit >= 5, then shift {tens,units,value} left by 1.
REQ-014 After exactly 5 CONV steps, the FSM SHALL enter LATCH.
REQ-015 LATCH SHALL copy scratch tens/units into display digit registers in one clock and return to IDLE.
REQ-016 Latency SHALL be fixed: load accepted at edge 0, busy high after edges 0..5, new digits visible and busy=0 after edge 6.
REQ-017 Display digit registers SHALL hold the previous result during CONV; they SHALL change only in LATCH or reset.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0, toggling digit select sel on each wrap.
REQ-019 With sel=0, the block SHALL drive an=2'b10 and seg=encoding(units).
REQ-020 With sel=1 and tens!=0, the block SHALL drive an=2'b01 and seg=encoding(tens).
REQ-021 With sel=1 and tens=0 (leading-zero blanking), the block SHALL drive an=2'b11 and seg=7'b1111111.
REQ-022 Encodings SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 The refresh counter and sel SHALL run independently of FSM state; a load SHALL never reset them.
REQ-024 an and seg SHALL be driven from registered state only, with no combinational path from load, cout or S.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, busy=0, value/scratch/shift count=0, display digits=0, refresh counter=0, sel=0, giving an=2'b10 and seg=1000000.
REQ-026 Reset asserted during CONV or LATCH SHALL abort the conversion with no partial digit update surviving.
REQ-027 After rst falls, the first rising clock edge SHALL be able to accept load.

Verification
REQ-028 Reset -> an=10, seg=1000000, busy=0 with no clock edge required.
REQ-029 With REFRESH_DIV=4, load with cout=1, S=1110 (30) -> busy=1 for 6 cycles; then units slot seg=1000000 and tens slot an=01, seg=0110000.
REQ-030 Load with cout=0, S=0111 (7) -> units seg=1111000; tens slot an=11, seg=1111111.
REQ-031 Load 5 then load 30 on edge 3 -> second load ignored; result digits 0,5 with tens blanked.
REQ-032 Load 31, then rst pulse at edge 3 -> display 0, busy=0; a new load of 9 after reset -> units seg=0010000.
REQ-033 REFRESH_DIV=4 free-running -> sel toggles every 4 cycles; exhaustive sweep of all 32 {cout,S} values -> digits match value/10 and value%10.
